hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
- Next-generation pipeline hazard controller for the 5-stage RISC-V core; supersedes the purely combinational load-use detector.
- Adds x0 exclusion, optional load-use detection against the MEM stage, and global freeze on data-memory wait states.
- Adds a counted stall for multi-cycle mul/div ops in EX, branch flush generation, and a saturating stall-cycle counter.
- Sits beside the ID stage; drives PC, IF/ID, ID/EX and EX/MEM write enables, bubble and flush controls.

Parameters:
REG_W, 5, register-address width
MULDIV_LAT, 4, total cycles a mul/div op occupies EX (>=1)
FWD_FROM_MEM, 1, 1 = MEM->EX forwarding exists; 0 = loads in MEM also cause load-use stall
CNT_W, 16, stall_count width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
rs1_id  in  REG_W  ID source 1
rs2_id  in  REG_W  ID source 2
use_rs1_id  in  1  ID instr reads rs1
use_rs2_id  in  1  ID instr reads rs2
rd_ex  in  REG_W  EX destination
MemRead_ex  in  1  EX instr is a load
rd_mem  in  REG_W  MEM destination
MemRead_mem  in  1  MEM instr is a load
mem_req_mem  in  1  MEM instr accesses data memory (load or store)
dmem_ready  in  1  data memory completes access this cycle
muldiv_ex  in  1  EX holds a mul/div op
branch_taken_ex  in  1  EX resolves taken branch/jump
load_delay  out  1  insert bubble into ID/EX
PCWrite  out  1  PC update enable
IF_ID_Write  out  1  IF/ID write enable
ID_EX_Write  out  1  ID/EX write enable
EX_MEM_Write  out  1  EX/MEM write enable
ex_bubble  out  1  load bubble into EX/MEM
flush_if_id  out  1  clear IF/ID
flush_id_ex  out  1  clear ID/EX
muldiv_busy  out  1  mul/div stall active
stall_count  out  CNT_W  cycles with PCWrite=0, saturating

Behaviour:
- Reset (async): state=IDLE, cnt=0, stall_count=0. While reset is high, outputs are forced to load_delay=0, PCWrite=IF_ID_Write=ID_EX_Write=EX_MEM_Write=1, ex_bubble=flush_*=muldiv_busy=0. Reset mid-BUSY aborts to IDLE immediately.
- Hazard terms (combinational):
  - hit(rd) = rd!=0 && ((rs1_id==rd && use_rs1_id) || (rs2_id==rd && use_rs2_id)).
  - load_use = MemRead_ex && hit(rd_ex), OR'd with (FWD_FROM_MEM==0 && MemRead_mem && hit(rd_mem)).
  - mem_stall = mem_req_mem && !dmem_ready.
- FSM states IDLE and BUSY; cnt width clog2(MULDIV_LAT)+1.
  - md_stall = (IDLE && muldiv_ex && MULDIV_LAT>1) || (BUSY && cnt!=0).
  - IDLE -> BUSY, cnt=MULDIV_LAT-2, when muldiv_ex && MULDIV_LAT>1 && !mem_stall.
  - In BUSY, when !mem_stall: cnt!=0 decrements; cnt==0 returns to IDLE (op leaves EX that edge). A muldiv_ex seen on the following IDLE cycle is a new op.
  - mem_stall freezes state and cnt.
- Priority, highest first:
  1. mem_stall: all four write enables 0, no bubble, no flush, load_delay=0.
  2. md_stall: PCWrite=IF_ID_Write=ID_EX_Write=0, EX_MEM_Write=1, ex_bubble=1, muldiv_busy=1.
  3. branch_taken_ex: flush_if_id=1, flush_id_ex=1, all enables 1, load_delay=0. A load-use on the wrong-path ID instruction is ignored.
  4. load_use: load_delay=1, PCWrite=0, IF_ID_Write=0, other enables 1.
  5. Otherwise: all enables 1, controls 0.
- muldiv_ex and branch_taken_ex are never both high (decode guarantee); if both are high, muldiv wins.
- stall_count increments by 1 on each clock edge where PCWrite==0; it holds at all-ones.
- With FWD_FROM_MEM=0, a load followed by a dependent instruction yields 2 bubbles.

Test Plan:
- Load-use: MemRead_ex=1, rd_ex=5, rs1_id=5, use_rs1_id=1 -> load_delay=1, PCWrite=0, IF_ID_Write=0, stall_count +1. Same with rd_ex=0 -> no stall.
- MULDIV_LAT=4: muldiv_ex pulse held while in EX -> muldiv_busy=1 for exactly 3 cycles, ex_bubble=1 for those 3 cycles, release on 4th. Back-to-back op -> a second 3-cycle stall. MULDIV_LAT=1 -> no stall.
- Mem wait: mem_req_mem=1, dmem_ready=0 for 2 cycles during BUSY cnt=1 -> all enables 0, cnt holds at 1, total busy extends by 2 cycles.
- Branch over load-use: branch_taken_ex=1 with a load-use match -> flush_if_id=flush_id_ex=1, load_delay=0, PCWrite=1.
- FWD_FROM_MEM=0: load x7, then dependent add -> load_delay=1 on two consecutive cycles; with FWD_FROM_MEM=1 -> one cycle.
- Async reset mid-BUSY (cnt=2) and with stall_count=0xFFFE -> state IDLE and stall_count=0 immediately without a clock edge. Separately, drive 3 stall cycles from 0xFFFE -> saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_mc_if
//  Purpose  : Bundles the pipeline-side signals seen by the hazard controller.
//             The pipeline (master) drives register addresses, load/mem/muldiv
//             status and branch resolution; the controller (slave) returns
//             write enables, bubble/flush controls and the stall counter.
//  Ports    : none (interface); modports master / slave
//  Revision : 1.0  initial release
// ============================================================================
interface hazard_ctrl_mc_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    // pipeline status towards the controller
    logic [REG_W-1:0] rs1_id;
    logic [REG_W-1:0] rs2_id;
    logic             use_rs1_id;
    logic             use_rs2_id;
    logic [REG_W-1:0] rd_ex;
    logic             MemRead_ex;
    logic [REG_W-1:0] rd_mem;
    logic             MemRead_mem;
    logic             mem_req_mem;
    logic             dmem_ready;
    logic             muldiv_ex;
    logic             branch_taken_ex;

    // controller decisions towards the pipeline
    logic             load_delay;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             ID_EX_Write;
    logic             EX_MEM_Write;
    logic             ex_bubble;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             muldiv_busy;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id,
        output rd_ex, MemRead_ex, rd_mem, MemRead_mem,
        output mem_req_mem, dmem_ready, muldiv_ex, branch_taken_ex,
        input  load_delay, PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
        input  ex_bubble, flush_if_id, flush_id_ex, muldiv_busy, stall_count
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id,
        input  rd_ex, MemRead_ex, rd_mem, MemRead_mem,
        input  mem_req_mem, dmem_ready, muldiv_ex, branch_taken_ex,
        output load_delay, PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
        output ex_bubble, flush_if_id, flush_id_ex, muldiv_busy, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_mc
//  Purpose  : Hazard controller for a 5-stage RISC-V pipeline. Detects
//             load-use hazards (EX, and MEM when no MEM->EX forwarding),
//             freezes the whole pipe on data-memory wait states, holds the
//             front end for multi-cycle mul/div ops in EX, flushes the wrong
//             path on taken branches and counts stalled cycles (saturating).
//  Ports    : clk    - clock
//             reset  - asynchronous active-high reset
//             hz     - hazard_ctrl_mc_if.slave: pipeline status in,
//                      write enables / bubble / flush / stall_count out
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_mc #(
    parameter int REG_W        = 5,
    parameter int MULDIV_LAT   = 4,
    parameter int FWD_FROM_MEM = 1,
    parameter int CNT_W        = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    hazard_ctrl_mc_if.slave    hz
);

    localparam int                    c_CNT_BITS = $clog2(MULDIV_LAT) + 1;
    // Cycles still to stall once the op has entered BUSY (first stall cycle
    // is spent in IDLE).
    localparam logic [c_CNT_BITS-1:0] c_CNT_INIT =
        c_CNT_BITS'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);
    localparam logic                  c_MD_EN    = (MULDIV_LAT > 1);
    localparam logic                  c_MEM_LU   = (FWD_FROM_MEM == 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_BITS-1:0] r_cnt;
    logic [c_CNT_BITS-1:0] w_cnt_nxt;
    logic [CNT_W-1:0]      r_stall_count;

    logic w_mem_stall;
    logic w_md_stall;
    logic w_load_use;

    logic w_load_delay;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_id_ex_write;
    logic w_ex_mem_write;
    logic w_ex_bubble;
    logic w_flush_if_id;
    logic w_flush_id_ex;
    logic w_muldiv_busy;

    // x0 is never a real dependency.
    function automatic logic reads_reg(input logic [REG_W-1:0] rd);
        return (rd != '0) &&
               (((hz.rs1_id == rd) && hz.use_rs1_id) ||
                ((hz.rs2_id == rd) && hz.use_rs2_id));
    endfunction

    assign w_mem_stall = hz.mem_req_mem && !hz.dmem_ready;
    assign w_load_use  = (hz.MemRead_ex && reads_reg(hz.rd_ex)) ||
                         (c_MEM_LU && hz.MemRead_mem && reads_reg(hz.rd_mem));
    assign w_md_stall  = ((r_state == ST_IDLE) && hz.muldiv_ex && c_MD_EN) ||
                         ((r_state == ST_BUSY) && (r_cnt != '0));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A memory wait state freezes the mul/div sequencer along with the pipe.
    // The cnt==0 BUSY cycle is the op's last cycle in EX, so a muldiv_ex seen
    // there still belongs to the old op and is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!w_mem_stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (hz.muldiv_ex && c_MD_EN) begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------- control outputs
    // muldiv_busy reports the mul/div stall as a status, so it stays up while
    // a memory wait freezes the op.
    always_comb begin
        w_load_delay   = 1'b0;
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_id_ex_write  = 1'b1;
        w_ex_mem_write = 1'b1;
        w_ex_bubble    = 1'b0;
        w_flush_if_id  = 1'b0;
        w_flush_id_ex  = 1'b0;
        w_muldiv_busy  = 1'b0;
        if (!reset) begin
            w_muldiv_busy = w_md_stall;
            if (w_mem_stall) begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_write  = 1'b0;
                w_ex_mem_write = 1'b0;
            end else if (w_md_stall) begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_id_ex_write = 1'b0;
                w_ex_bubble   = 1'b1;
            end else if (hz.branch_taken_ex) begin
                // wrong-path ID instruction: its load-use is irrelevant
                w_flush_if_id = 1'b1;
                w_flush_id_ex = 1'b1;
            end else if (w_load_use) begin
                w_load_delay  = 1'b1;
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
            end
        end
    end

    // ------------------------------------------------------- stall counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (!w_pc_write && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign hz.load_delay   = w_load_delay;
    assign hz.PCWrite      = w_pc_write;
    assign hz.IF_ID_Write  = w_if_id_write;
    assign hz.ID_EX_Write  = w_id_ex_write;
    assign hz.EX_MEM_Write = w_ex_mem_write;
    assign hz.ex_bubble    = w_ex_bubble;
    assign hz.flush_if_id  = w_flush_if_id;
    assign hz.flush_id_ex  = w_flush_id_ex;
    assign hz.muldiv_busy  = w_muldiv_busy;
    assign hz.stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_mc
//  Purpose  : Scoreboard bench for hazard_ctrl_mc. Two instances share the
//             stimulus: dut0 (MULDIV_LAT=4, MEM forwarding, 16-bit counter)
//             and dut1 (MULDIV_LAT=1, no MEM forwarding, 4-bit counter).
//             Expected outputs come from a cycle model built on an "age of
//             the mul/div op" view and the priority rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_mc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_mc_if #(.REG_W(5), .CNT_W(16)) if0 ();
    hazard_ctrl_mc_if #(.REG_W(5), .CNT_W(4))  if1 ();

    hazard_ctrl_mc #(.REG_W(5), .MULDIV_LAT(4), .FWD_FROM_MEM(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(rst), .hz(if0.slave));
    hazard_ctrl_mc #(.REG_W(5), .MULDIV_LAT(1), .FWD_FROM_MEM(0), .CNT_W(4)) dut1 (
        .clk(clk), .reset(rst), .hz(if1.slave));

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd_ex;
        logic       mr_ex;
        logic [4:0] rd_mem;
        logic       mr_mem;
        logic       mreq;
        logic       dready;
        logic       md;
        logic       br;
    } stim_t;

    // output vector: [24] load_delay [23] PCWrite [22] IF_ID [21] ID_EX
    // [20] EX_MEM [19] ex_bubble [18] flush_if_id [17] flush_id_ex
    // [16] muldiv_busy [15:0] stall_count
    typedef struct packed {
        logic [1:0][24:0] v;
        logic [1:0][24:0] m;
        int               cyc;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    // reference model state
    int   in_op [2];
    int   age   [2];
    int   scnt  [2];

    function automatic int cfg_lat(int k);  return (k == 0) ? 4 : 1;      endfunction
    function automatic int cfg_fwd(int k);  return (k == 0) ? 1 : 0;      endfunction
    function automatic int cfg_max(int k);  return (k == 0) ? 65535 : 15; endfunction

    function automatic bit dep(stim_t s, logic [4:0] rd);
        return (rd != 0) && ((s.rs1 == rd && s.use1) || (s.rs2 == rd && s.use2));
    endfunction

    function automatic logic [24:0] model_out(int k, stim_t s, output logic [24:0] mask);
        bit ms, md, lu;
        logic [24:0] e;
        mask = '1;
        e = {1'b0, 4'b1111, 4'b0000, 16'(scnt[k])};
        if (s.rst) begin
            e[15:0] = '0;
            return e;
        end
        ms = s.mreq && !s.dready;
        md = (in_op[k] != 0) ? (age[k] < cfg_lat(k) - 1) : (s.md && cfg_lat(k) > 1);
        lu = (s.mr_ex && dep(s, s.rd_ex)) ||
             (cfg_fwd(k) == 0 && s.mr_mem && dep(s, s.rd_mem));
        e[16] = md;
        if (ms) begin
            e[23:20] = 4'b0000;
            mask[16] = 1'b0;
        end else if (md) begin
            e[23:21] = 3'b000;
            e[19]    = 1'b1;
        end else if (s.br) begin
            e[18] = 1'b1;
            e[17] = 1'b1;
        end else if (lu) begin
            e[24] = 1'b1;
            e[23] = 1'b0;
            e[22] = 1'b0;
        end
        return e;
    endfunction

    function automatic void model_step(int k, stim_t s, logic [24:0] e);
        bit ms;
        if (s.rst) begin
            in_op[k] = 0; age[k] = 0; scnt[k] = 0;
            return;
        end
        ms = s.mreq && !s.dready;
        if (!ms) begin
            if (in_op[k] != 0) begin
                if (age[k] == cfg_lat(k) - 1) in_op[k] = 0;
                else                         age[k]++;
            end else if (s.md && cfg_lat(k) > 1) begin
                in_op[k] = 1;
                age[k]   = 1;
            end
        end
        if (!e[23] && scnt[k] < cfg_max(k)) scnt[k]++;
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic apply(stim_t s);
        rst = s.rst;
        if0.rs1_id = s.rs1;   if1.rs1_id = s.rs1;
        if0.rs2_id = s.rs2;   if1.rs2_id = s.rs2;
        if0.use_rs1_id = s.use1; if1.use_rs1_id = s.use1;
        if0.use_rs2_id = s.use2; if1.use_rs2_id = s.use2;
        if0.rd_ex = s.rd_ex;  if1.rd_ex = s.rd_ex;
        if0.MemRead_ex = s.mr_ex;   if1.MemRead_ex = s.mr_ex;
        if0.rd_mem = s.rd_mem; if1.rd_mem = s.rd_mem;
        if0.MemRead_mem = s.mr_mem; if1.MemRead_mem = s.mr_mem;
        if0.mem_req_mem = s.mreq;   if1.mem_req_mem = s.mreq;
        if0.dmem_ready = s.dready;  if1.dmem_ready = s.dready;
        if0.muldiv_ex = s.md;       if1.muldiv_ex = s.md;
        if0.branch_taken_ex = s.br; if1.branch_taken_ex = s.br;
    endtask

    // model the cycle whose inputs were just applied and queue the result
    task automatic expect_cycle(stim_t s);
        exp_t x;
        logic [24:0] m;
        for (int k = 0; k < 2; k++) begin
            x.v[k] = model_out(k, s, m);
            x.m[k] = m;
        end
        x.cyc = cycle;
        sbq.push_back(x);
        for (int k = 0; k < 2; k++) model_step(k, s, x.v[k]);
        cycle++;
    endtask

    task automatic drive_cycle(stim_t s);
        @(posedge clk);
        #1;
        apply(s);
        expect_cycle(s);
    endtask

    function automatic stim_t idle_stim();
        stim_t s = '0;
        s.dready = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst    = 1'b0;
        s.rs1    = 5'($urandom_range(0, 3));
        s.rs2    = 5'($urandom_range(0, 3));
        s.use1   = 1'($urandom_range(0, 1));
        s.use2   = 1'($urandom_range(0, 1));
        s.rd_ex  = 5'($urandom_range(0, 3));
        s.mr_ex  = 1'($urandom_range(0, 1));
        s.rd_mem = 5'($urandom_range(0, 3));
        s.mr_mem = 1'($urandom_range(0, 1));
        s.mreq   = 1'($urandom_range(0, 1));
        s.dready = ($urandom_range(0, 3) != 0);
        s.md     = ($urandom_range(0, 5) == 0);
        s.br     = ($urandom_range(0, 5) == 0);
        return s;
    endfunction

    function automatic logic [24:0] act_vec(int k);
        if (k == 0)
            return {if0.load_delay, if0.PCWrite, if0.IF_ID_Write, if0.ID_EX_Write,
                    if0.EX_MEM_Write, if0.ex_bubble, if0.flush_if_id, if0.flush_id_ex,
                    if0.muldiv_busy, if0.stall_count};
        return {if1.load_delay, if1.PCWrite, if1.IF_ID_Write, if1.ID_EX_Write,
                if1.EX_MEM_Write, if1.ex_bubble, if1.flush_if_id, if1.flush_id_ex,
                if1.muldiv_busy, 12'h000, if1.stall_count};
    endfunction

    // monitor: compare whatever the DUTs present against the oldest prediction
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t x;
            x = sbq.pop_front();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d cycle %0d outputs", k, x.cyc),
                      {7'd0, act_vec(k) & x.m[k]}, {7'd0, x.v[k] & x.m[k]});
            end
        end
    end

    initial begin
        stim_t s;
        for (int k = 0; k < 2; k++) begin in_op[k] = 0; age[k] = 0; scnt[k] = 0; end
        s = idle_stim();
        s.rst = 1'b1;
        apply(s);

        // reset state
        drive_cycle(s);
        drive_cycle(s);

        // load-use on rd_ex=5, then the same with rd_ex=0 (x0 never stalls)
        s = idle_stim(); s.mr_ex = 1; s.rd_ex = 5; s.rs1 = 5; s.use1 = 1;
        drive_cycle(s);
        s.rd_ex = 0; s.rs1 = 0;
        drive_cycle(s);

        // two back-to-back mul/div ops, each held in EX for 4 cycles
        s = idle_stim(); s.md = 1;
        repeat (8) drive_cycle(s);
        s = idle_stim();
        drive_cycle(s);

        // memory wait while the op sits at its last stall cycle
        s = idle_stim(); s.md = 1;
        drive_cycle(s);
        drive_cycle(s);
        s.mreq = 1; s.dready = 0;
        drive_cycle(s);
        drive_cycle(s);
        s.mreq = 1; s.dready = 1;
        drive_cycle(s);
        drive_cycle(s);
        s = idle_stim();
        drive_cycle(s);

        // taken branch overrides a load-use on the wrong-path instruction
        s = idle_stim(); s.br = 1; s.mr_ex = 1; s.rd_ex = 3; s.rs2 = 3; s.use2 = 1;
        drive_cycle(s);

        // load x7 then dependent add: one bubble with MEM forwarding, two without
        s = idle_stim(); s.mr_ex = 1; s.rd_ex = 7; s.rs1 = 7; s.use1 = 1;
        drive_cycle(s);
        s.mr_ex = 0; s.rd_ex = 0; s.mr_mem = 1; s.rd_mem = 7;
        drive_cycle(s);
        s = idle_stim();
        drive_cycle(s);

        // long memory wait: dut1's 4-bit counter must saturate
        s = idle_stim(); s.mreq = 1; s.dready = 0;
        repeat (20) drive_cycle(s);

        // randomized traffic
        repeat (3000) drive_cycle(rand_stim());

        // asynchronous reset while dut0 is BUSY with two stall cycles left
        s = idle_stim(); s.md = 1;
        drive_cycle(s);
        @(posedge clk);
        #1;
        check("dut0 busy before reset", {31'd0, if0.muldiv_busy}, 32'd1);
        s.rst = 1'b1;
        apply(s);
        #1;
        check("dut0 reset PCWrite", {31'd0, if0.PCWrite}, 32'd1);
        check("dut0 reset muldiv_busy", {31'd0, if0.muldiv_busy}, 32'd0);
        check("dut0 reset stall_count", {16'd0, if0.stall_count}, 32'd0);
        check("dut1 reset stall_count", {28'd0, if1.stall_count}, 32'd0);
        expect_cycle(s);
        s = idle_stim(); s.md = 1;
        repeat (5) drive_cycle(s);

        repeat (300) drive_cycle(rand_stim());

        @(negedge clk);
        #1;
        check("scoreboard drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
